// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single DataMemory port between the CPU (zero-latency, default
// priority) and a loader/debug requester using a registered req/ack handshake.
module dmem_port_arbiter #(
  parameter int unsigned AW       = 64,
  parameter int unsigned DW       = 64,
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned CW       = 3
) (
  input  logic          CLK,
  input  logic          resetl,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic          ldr_ack,
  output logic [DW-1:0] ldr_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  localparam logic [CW-1:0] MAX_WAIT_C = CW'(MAX_WAIT);

  state_t        state, state_nxt;
  logic [CW-1:0] wait_cnt, wait_cnt_nxt;
  logic          cpu_req, ldr_elig, force_ldr, gnt_ldr, gnt_cpu;

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      ldr_ack   <= 1'b0;
      ldr_rdata <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      ldr_ack  <= gnt_ldr;
      if (gnt_ldr && !ldr_we)
        ldr_rdata <= mem_rdata;
    end
  end

  always_comb begin
    state_nxt    = S_IDLE;
    wait_cnt_nxt = '0;
    case (state)
      S_IDLE, S_WAIT: begin
        if (gnt_ldr) begin
          state_nxt = S_ACK;
        end else if (ldr_req) begin
          state_nxt    = S_WAIT;
          wait_cnt_nxt = (wait_cnt == MAX_WAIT_C) ? wait_cnt : wait_cnt + 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Grants and memory mux; a simultaneous rd+wr from the CPU is a write.
  always_comb begin
    cpu_req   = cpu_rd | cpu_wr;
    ldr_elig  = ldr_req & (state != S_ACK);
    force_ldr = (wait_cnt == MAX_WAIT_C);
    gnt_ldr   = ldr_elig & (~cpu_req | force_ldr);
    gnt_cpu   = cpu_req & ~gnt_ldr;
    cpu_stall = cpu_req & ~gnt_cpu;
    cpu_rdata = mem_rdata;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (gnt_cpu) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_write = cpu_wr;
      mem_read  = cpu_rd & ~cpu_wr;
    end else if (gnt_ldr) begin
      mem_addr  = ldr_addr;
      mem_wdata = ldr_wdata;
      mem_write = ldr_we;
      mem_read  = ~ldr_we;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a small combinational-read memory model.
module tb_dmem_port_arbiter;

  logic        CLK;
  logic        resetl;
  logic        cpu_rd, cpu_wr;
  logic [63:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        ldr_req, ldr_we;
  logic [63:0] ldr_addr, ldr_wdata;
  logic        ldr_ack;
  logic [63:0] ldr_rdata;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  logic [63:0] mem [0:255];
  int          errors = 0;
  int          checks = 0;
  int          both_cnt = 0;

  dmem_port_arbiter #(.AW(64), .DW(64), .MAX_WAIT(4), .CW(3)) dut (
    .CLK(CLK), .resetl(resetl),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  assign mem_rdata = mem[mem_addr[7:0]];

  always @(posedge CLK) begin
    if (mem_write) mem[mem_addr[7:0]] = mem_wdata;
  end

  always @(negedge CLK) begin
    if (mem_read && mem_write) both_cnt = both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    for (int unsigned i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h18] = 64'h5A5A_0000_0000_5A5A;
    resetl    = 1'b0;
    cpu_rd    = 1'b0;
    cpu_wr    = 1'b1;
    cpu_addr  = 64'h40;
    cpu_wdata = 64'h1111;
    ldr_req   = 1'b1;
    ldr_we    = 1'b0;
    ldr_addr  = 64'h18;
    ldr_wdata = '0;

    // Reset with both requesters asserted
    repeat (2) tick();
    chk("rst_ack", {63'd0, ldr_ack}, 64'd0);
    chk("rst_rdata", ldr_rdata, 64'd0);
    chk("rst_stall", {63'd0, cpu_stall}, 64'd0);
    @(negedge CLK);
    resetl = 1'b1;
    #1;
    chk("rel_stall", {63'd0, cpu_stall}, 64'd0);
    chk("rel_mwr", {63'd0, mem_write}, 64'd1);
    chk("rel_mrd", {63'd0, mem_read}, 64'd0);
    chk("rel_maddr", mem_addr, 64'h40);
    cpu_wr  = 1'b0;
    ldr_req = 1'b0;
    #1;
    chk("idle_maddr", mem_addr, 64'd0);
    chk("idle_mwr", {63'd0, mem_write}, 64'd0);
    chk("idle_mrd", {63'd0, mem_read}, 64'd0);
    tick();

    // Loader write then read-back, CPU idle
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 64'h10; ldr_wdata = 64'hDEAD;
    #1;
    chk("lw_mwr", {63'd0, mem_write}, 64'd1);
    chk("lw_maddr", mem_addr, 64'h10);
    chk("lw_mwdata", mem_wdata, 64'hDEAD);
    chk("lw_ack0", {63'd0, ldr_ack}, 64'd0);
    tick();
    chk("lw_ack1", {63'd0, ldr_ack}, 64'd1);
    chk("lw_mem", mem[8'h10], 64'hDEAD);
    ldr_req = 1'b0;
    #1;
    chk("lw_ackst_mwr", {63'd0, mem_write}, 64'd0);
    tick();
    chk("lw_ack_clr", {63'd0, ldr_ack}, 64'd0);
    ldr_req = 1'b1; ldr_we = 1'b0;
    #1;
    chk("lr_mrd", {63'd0, mem_read}, 64'd1);
    tick();
    chk("lr_ack", {63'd0, ldr_ack}, 64'd1);
    chk("lr_rdata", ldr_rdata, 64'hDEAD);
    ldr_req = 1'b0;
    tick();

    // Starvation bound under continuous CPU reads
    cpu_rd = 1'b1; cpu_addr = 64'h10;
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 64'h18;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("sv_stall%0d", i), {63'd0, cpu_stall}, (i == 4) ? 64'd1 : 64'd0);
      chk($sformatf("sv_maddr%0d", i), mem_addr, (i == 4) ? 64'h18 : 64'h10);
      chk($sformatf("sv_ack%0d", i), {63'd0, ldr_ack}, 64'd0);
      tick();
    end
    chk("sv_ack", {63'd0, ldr_ack}, 64'd1);
    chk("sv_rdata", ldr_rdata, 64'h5A5A_0000_0000_5A5A);
    ldr_req = 1'b0;
    #1;
    chk("sv_stall_after", {63'd0, cpu_stall}, 64'd0);
    chk("sv_cpu_rdata", cpu_rdata, 64'hDEAD);
    tick();
    chk("sv_ack_clr", {63'd0, ldr_ack}, 64'd0);
    cpu_rd = 1'b0;
    tick();

    // Back-to-back loader requests alternate with the ACK cycle
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 64'h30; ldr_wdata = 64'h77;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("alt_mwr%0d", i), {63'd0, mem_write}, (i % 2 == 0) ? 64'd1 : 64'd0);
      tick();
      chk($sformatf("alt_ack%0d", i), {63'd0, ldr_ack}, (i % 2 == 0) ? 64'd1 : 64'd0);
    end
    ldr_req = 1'b0;
    tick();

    // Competing writes to the same address land in grant order
    cpu_wr = 1'b1; cpu_addr = 64'h20; cpu_wdata = 64'h1;
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 64'h20; ldr_wdata = 64'h2;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("ww_stall%0d", i), {63'd0, cpu_stall}, (i == 4) ? 64'd1 : 64'd0);
      chk($sformatf("ww_wdata%0d", i), mem_wdata, (i == 4) ? 64'h2 : 64'h1);
      tick();
    end
    chk("ww_mem_ldr", mem[8'h20], 64'h2);
    chk("ww_ack", {63'd0, ldr_ack}, 64'd1);
    ldr_req = 1'b0;
    #1;
    chk("ww_stall_after", {63'd0, cpu_stall}, 64'd0);
    tick();
    chk("ww_mem_cpu", mem[8'h20], 64'h1);
    cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_addr = 64'h28; cpu_wdata = 64'h99;
    #1;
    chk("rdwr_mwr", {63'd0, mem_write}, 64'd1);
    chk("rdwr_mrd", {63'd0, mem_read}, 64'd0);
    tick();
    chk("rdwr_mem", mem[8'h28], 64'h99);
    cpu_rd = 1'b0; cpu_wr = 1'b0;
    tick();

    // Reset pulse while the loader waits with a partially counted wait
    cpu_rd = 1'b1; cpu_addr = 64'h10;
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 64'h30;
    repeat (3) begin
      #1;
      chk("rw_stall_pre", {63'd0, cpu_stall}, 64'd0);
      tick();
    end
    #2 resetl = 1'b0;
    #1;
    chk("rw_rst_ack", {63'd0, ldr_ack}, 64'd0);
    chk("rw_rst_rdata", ldr_rdata, 64'd0);
    #2 resetl = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("rw_stall%0d", i), {63'd0, cpu_stall}, (i == 4) ? 64'd1 : 64'd0);
      chk($sformatf("rw_ack%0d", i), {63'd0, ldr_ack}, 64'd0);
      tick();
    end
    chk("rw_ack", {63'd0, ldr_ack}, 64'd1);
    chk("rw_rdata", ldr_rdata, 64'h77);
    ldr_req = 1'b0; cpu_rd = 1'b0;
    tick();

    chk("rw_excl", 64'(both_cnt), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single DataMemory port between the CPU datapath (requester 0) and a program/data loader or debug port (requester 1).
- The CPU has default priority and sees a zero-latency grant. When it loses arbitration it gets a combinational stall that holds the PC and suppresses register writeback.
- The loader uses a registered req/ack handshake. A wait counter guarantees the loader gets a slot.
- Sits between the CPU's aluout/regoutB/memread/memwrite signals and DataMemory.

Parameters:
- AW, 64, address width
- DW, 64, data width
- MAX_WAIT, 4, loader wait cycles (≥1) before it preempts the CPU for one cycle
- CW, 3, wait-counter width; must satisfy 2^CW > MAX_WAIT

Ports:
- CLK  in  1  clock; all state updates on posedge
- resetl  in  1  asynchronous, active-low reset
- cpu_rd  in  1  CPU memread
- cpu_wr  in  1  CPU memwrite
- cpu_addr  in  AW  CPU address (aluout)
- cpu_wdata  in  DW  CPU store data
- cpu_rdata  out  DW  combinational pass-through of mem_rdata
- cpu_stall  out  1  CPU access not granted this cycle
- ldr_req  in  1  loader request; held stable until ldr_ack
- ldr_we  in  1  1 = write, 0 = read
- ldr_addr  in  AW  loader address
- ldr_wdata  in  DW  loader write data
- ldr_ack  out  1  one-cycle pulse: access completed
- ldr_rdata  out  DW  registered read data, valid with ldr_ack
- mem_addr  out  AW  to DataMemory Address
- mem_wdata  out  DW  to DataMemory WriteData
- mem_read  out  1  to DataMemory MemoryRead
- mem_write  out  1  to DataMemory MemoryWrite
- mem_rdata  in  DW  from DataMemory ReadData (combinational read)

Behaviour:
- cpu_req = cpu_rd | cpu_wr. If cpu_rd and cpu_wr are both high, the access is treated as a write.
- Loader FSM: IDLE, WAIT, ACK. It is registered and reset to IDLE.
- Registered state: wait_cnt = 0, ldr_ack = 0, ldr_rdata = 0.
- ldr_elig = ldr_req & (state != ACK).
- force = (wait_cnt == MAX_WAIT).
- Grant rules (combinational):
  - gnt_ldr = ldr_elig & (~cpu_req | force)
  - gnt_cpu = cpu_req & ~gnt_ldr
- cpu_stall = cpu_req & ~gnt_cpu.
- Memory side:
  - When gnt_cpu: mem_* driven from the cpu_* inputs.
  - When gnt_ldr: mem_* driven from the ldr_* inputs.
  - When neither: mem_read = mem_write = 0, mem_addr = 0, mem_wdata = 0.
  - mem_read and mem_write are never both 1.
- Loader FSM transitions, evaluated at posedge:
  - IDLE/WAIT with gnt_ldr → ACK. Same edge: ldr_ack <= 1; ldr_rdata <= mem_rdata on a read, otherwise unchanged; wait_cnt <= 0.
  - IDLE/WAIT with ldr_req and no grant → WAIT; wait_cnt <= wait_cnt + 1, saturating at MAX_WAIT.
  - ACK → IDLE; ldr_ack <= 0.
  - IDLE/WAIT with ldr_req low → IDLE; wait_cnt <= 0. A withdrawn request is legal only before it is granted.
- Latency:
  - CPU access has zero latency when granted.
  - Loader ack arrives on the posedge after its grant cycle.
  - Loader access is then blocked for one cycle (ACK state), so maximum loader throughput is one access per 2 cycles.
- Starvation bound: under continuous cpu_req, a loader request is granted on its (MAX_WAIT+1)th cycle. The CPU stalls exactly that one cycle, then regains the port.
- Simultaneous writes to the same address are serialized in grant order.
- Reset (asynchronous, any time):
  - FSM → IDLE; wait_cnt, ldr_ack, ldr_rdata → 0.
  - An in-flight loader request is dropped and no ack is issued.
  - cpu_stall follows the combinational grant rules from the reset state.
  - Memory outputs are idle unless a requester is asserted.

Test Plan:
- Reset with ldr_req=1, cpu_wr=1 held → ldr_ack=0, ldr_rdata=0, wait_cnt=0. After release: CPU granted, cpu_stall=0, mem_write=1, mem_addr=cpu_addr.
- CPU idle; loader write addr 0x10, data 0xDEAD → mem_write=1 in grant cycle, ldr_ack=1 next cycle. Then loader read 0x10 → ldr_rdata=0xDEAD with ack.
- cpu_rd held high continuously, ldr_req raised at cycle t, MAX_WAIT=4 → cpu_stall=0 for t..t+3 and 1 at t+4 only. Loader granted at t+4, ldr_ack at t+5, cpu_stall=0 again at t+5.
- Loader holds ldr_req through ACK and into the next request, CPU idle → grants on alternate cycles only; ldr_ack pattern 1,0,1,0.
- cpu_wr and ldr forced write to the same address 0x20 (values 0x1 then 0x2) → the final memory value reflects the grant order. Neither requester ever gets mem_read and mem_write asserted together.
- resetl pulsed low during WAIT with wait_cnt=3 → after release: FSM in IDLE, no ldr_ack, wait_cnt restarts from 0.
